egress_frame_arbiter: RTL and testbench
=======================================

EGRESS_FRAME_ARBITER -- requirements
Module: egress_frame_arbiter

Interface
REQ-001 Parameter: NUM_PORTS, 4, number of ingress streams; fixed at 4, other values unsupported.
REQ-002 Port: clk  in  1  sole clock, all state on posedge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: ingress_port_tdata  in  64  four 16-bit lanes; port i on bits [16i+15:16i].
REQ-005 Port: ingress_port_tvalid  in  4  per-port beat valid.
REQ-006 Port: ingress_port_tlast  in  4  per-port last beat of frame.
REQ-007 Port: ingress_port_tready  out  4  per-port ready; nonzero only on the granted bit.
REQ-008 Port: egress_port_tdata  out  16  forwarded beat data.
REQ-009 Port: egress_port_tvalid  out  1  forwarded beat valid.
REQ-010 Port: egress_port_tlast  out  1  forwarded last beat.
REQ-011 Port: egress_port_tready  in  1  downstream ready.
REQ-012 Port: grant  out  4  one-hot current owner; 4'b0000 when idle.
REQ-013 Ports present only with ARB_STATS_EN: chipselect in 1, read in 1, address in 8, readdata out 8 (Avalon slave, 8-bit).

Function
REQ-014 States: IDLE, BUSY; a 2-bit round-robin pointer rr_ptr names the highest-priority port.
REQ-015 IDLE: if any ingress_port_tvalid bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ... modulo 4; register it into grant and enter BUSY next cycle.
REQ-016 IDLE: egress_port_tdata/tvalid/tlast are 0 and ingress_port_tready is 4'b0000.
REQ-017 BUSY: egress tdata/tvalid/tlast equal the granted lane's signals combinationally (zero-cycle latency); ingress_port_tready[g] = egress_port_tready, all other bits 0.
REQ-018 BUSY exit: on the cycle where the granted lane has tvalid & tlast & egress_port_tready, clear grant, set rr_ptr to (g+1) mod 4 and enter IDLE next cycle.
REQ-019 Frames are never preempted; a granted port deasserting tvalid mid-frame keeps the grant until its tlast handshake.
REQ-020 Exactly one IDLE cycle separates consecutive frames; maximum egress utilisation is N/(N+1) for N-beat frames.
REQ-021 A single-beat frame (tlast on first beat) is legal and completes in one BUSY cycle.
REQ-022 Non-granted ports see tready = 0 and hold their beats; no beat is dropped or duplicated.
REQ-023 A port requesting while rr_ptr points past it waits at most 3 frames (starvation bound).

Reset
REQ-024 Asynchronous assertion: state = IDLE, rr_ptr = 0, grant = 0, all egress outputs and ingress_port_tready = 0, readdata = 0, counters = 0.
REQ-025 Reset during BUSY truncates the frame; no tlast is generated for it; arbitration restarts from port 0 after release.

Configuration
REQ-026 Macro ARB_STATS_EN: when defined, per-port 16-bit completed-frame counters are built; when undefined, counters and the slave ports of REQ-013 are absent and function is otherwise identical.
REQ-027 With ARB_STATS_EN: counter[i] increments on each REQ-018 exit for port i, saturating at 16'hFFFF.
REQ-028 With ARB_STATS_EN: address 2i = counter[i][7:0], 2i+1 = counter[i][15:8] (i = 0..3), address 8 = {4'b0, grant}; other addresses read 8'h00.
REQ-029 With ARB_STATS_EN: readdata registered, valid one cycle after chipselect & read; 8'h00 on cycles without a read.

Verification
REQ-030 Only port 2 sends a 3-beat frame 16'h1111,16'h2222,16'h3333, egress_port_tready = 1 -> grant = 4'b0100 one cycle after tvalid, egress carries the three words, tlast on 16'h3333, then grant = 0, rr_ptr = 3.
REQ-031 All four ports hold 2-beat frames from reset -> egress order port 0,1,2,3, one idle cycle between frames, no port's data interleaved.
REQ-032 Port 1 granted, egress_port_tready low 5 cycles mid-frame, port 0 requesting -> egress beat held stable, ingress_port_tready = 0, grant stays 4'b0010 until tlast.
REQ-033 Port 3 single-beat frame with tlast set -> one BUSY cycle, egress_port_tlast = 1 same cycle, IDLE next cycle.
REQ-034 Reset asserted on beat 2 of a 4-beat port 0 frame -> all outputs 0 immediately, grant = 0, next request from port 1 and 0 together grants port 0.
REQ-035 ARB_STATS_EN, port 0 completes 3 frames, read address 0 then 1 -> readdata 8'h03 then 8'h00, each one cycle after read.

Source files
------------

// File: rtl/egress_frame_arbiter.sv
// Purpose: round-robin, frame-atomic arbiter merging four 16-bit ingress streams onto one egress stream.
// Latency: grant is registered one cycle after a request; beats then pass through combinationally.
// Backpressure: egress_port_tready passes straight to the granted port; other ports see tready = 0.
// Build option: define ARB_STATS_EN to add per-port frame counters behind an 8-bit read port.
module egress_frame_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [16*NUM_PORTS-1:0]  ingress_port_tdata,
  input  logic [NUM_PORTS-1:0]     ingress_port_tvalid,
  input  logic [NUM_PORTS-1:0]     ingress_port_tlast,
  output logic [NUM_PORTS-1:0]     ingress_port_tready,
  output logic [15:0]              egress_port_tdata,
  output logic                     egress_port_tvalid,
  output logic                     egress_port_tlast,
  input  logic                     egress_port_tready,
  output logic [NUM_PORTS-1:0]     grant
`ifdef ARB_STATS_EN
  ,
  input  logic                     chipselect,
  input  logic                     read,
  input  logic [7:0]               address,
  output logic [7:0]               readdata
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  gidx_q, gidx_d;

  logic [7:0]  vld_dbl;
  logic [3:0]  vld_rot;
  logic [1:0]  sel_off;
  logic [1:0]  sel_idx;
  logic        sel_vld;
  logic [15:0] lane_dat;
  logic        lane_vld;
  logic        lane_lst;
  logic        frame_done;

  assign grant = grant_q;

  // Rotate requests so rr_ptr sits at bit 0, then take the first requester after it.
  always_comb begin
    vld_dbl = {ingress_port_tvalid, ingress_port_tvalid} >> rr_ptr_q;
    vld_rot = vld_dbl[3:0];
    sel_vld = |vld_rot;
    casez (vld_rot)
      4'b???1: sel_off = 2'd0;
      4'b??10: sel_off = 2'd1;
      4'b?100: sel_off = 2'd2;
      4'b1000: sel_off = 2'd3;
      default: sel_off = 2'd0;
    endcase
    sel_idx  = rr_ptr_q + sel_off;
    lane_dat = ingress_port_tdata[gidx_q*16 +: 16];
    lane_vld = ingress_port_tvalid[gidx_q];
    lane_lst = ingress_port_tlast[gidx_q];
  end

  // Arbitration state, pointer and grant registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= 2'd0;
      grant_q  <= 4'b0000;
      gidx_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
    end
  end

  // Next-state and datapath steering: grant in IDLE, pass the owner's beats in BUSY until its tlast handshake.
  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    grant_d             = grant_q;
    gidx_d              = gidx_q;
    egress_port_tdata   = 16'h0000;
    egress_port_tvalid  = 1'b0;
    egress_port_tlast   = 1'b0;
    ingress_port_tready = '0;
    frame_done          = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = BUSY;
          grant_d = 4'b0001 << sel_idx;
          gidx_d  = sel_idx;
        end
      end
      BUSY: begin
        egress_port_tdata   = lane_dat;
        egress_port_tvalid  = lane_vld;
        egress_port_tlast   = lane_lst;
        ingress_port_tready = grant_q & {4{egress_port_tready}};
        if (lane_vld && lane_lst && egress_port_tready) begin
          frame_done = 1'b1;
          state_d    = IDLE;
          grant_d    = 4'b0000;
          rr_ptr_d   = gidx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_STATS_EN
  logic [15:0] cnt_q [4];
  logic [7:0]  readdata_q, readdata_d;

  assign readdata = readdata_q;

  // Read mux: even address = low counter byte, odd = high byte, 8 = live grant.
  always_comb begin
    readdata_d = 8'h00;
    if (chipselect && read) begin
      if (address < 8'd8) begin
        readdata_d = address[0] ? cnt_q[address[2:1]][15:8] : cnt_q[address[2:1]][7:0];
      end else if (address == 8'd8) begin
        readdata_d = {4'b0000, grant_q};
      end
    end
  end

  // Saturating completed-frame counters and registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 16'h0000;
      readdata_q <= 8'h00;
    end else begin
      if (frame_done && (cnt_q[gidx_q] != 16'hFFFF)) begin
        cnt_q[gidx_q] <= cnt_q[gidx_q] + 16'd1;
      end
      readdata_q <= readdata_d;
    end
  end
`endif

endmodule

// File: tb/tb_egress_frame_arbiter.sv
// Bench for egress_frame_arbiter: queue-fed ingress sources, a frame-level reference model compared every cycle,
// and directed scenarios with literal expectations on the egress beat log.
// Define ARB_STATS_EN to also exercise the counter read port.
module tb_egress_frame_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] ingress_port_tdata;
  logic [3:0]  ingress_port_tvalid;
  logic [3:0]  ingress_port_tlast;
  logic [3:0]  ingress_port_tready;
  logic [15:0] egress_port_tdata;
  logic        egress_port_tvalid;
  logic        egress_port_tlast;
  logic        egress_port_tready = 1'b1;
  logic [3:0]  grant;
`ifdef ARB_STATS_EN
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [7:0]  readdata;
`endif

  always #5 clk = ~clk;

  egress_frame_arbiter #(.NUM_PORTS(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ingress_port_tdata  (ingress_port_tdata),
    .ingress_port_tvalid (ingress_port_tvalid),
    .ingress_port_tlast  (ingress_port_tlast),
    .ingress_port_tready (ingress_port_tready),
    .egress_port_tdata   (egress_port_tdata),
    .egress_port_tvalid  (egress_port_tvalid),
    .egress_port_tlast   (egress_port_tlast),
    .egress_port_tready  (egress_port_tready),
    .grant               (grant)
`ifdef ARB_STATS_EN
    ,
    .chipselect          (chipselect),
    .read                (read),
    .address             (address),
    .readdata            (readdata)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- ingress sources: bit17 = bubble, bit16 = last, [15:0] = data
  logic [17:0] srcq [4][$];
  logic [3:0]  hs;
  logic [3:0]  bubble_now;

  task automatic push_beat(input int p, input logic [15:0] d, input logic last);
    srcq[p].push_back({1'b0, last, d});
  endtask

  task automatic push_bubble(input int p);
    srcq[p].push_back(18'h20000);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) srcq[i].delete();
    bubble_now = '0;
  endtask

  initial begin
    ingress_port_tdata  = '0;
    ingress_port_tvalid = '0;
    ingress_port_tlast  = '0;
    bubble_now          = '0;
    hs                  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) hs[i] = ingress_port_tvalid[i] & ingress_port_tready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if ((hs[i] || bubble_now[i]) && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0 && !srcq[i][0][17]) begin
          ingress_port_tvalid[i]         = 1'b1;
          ingress_port_tlast[i]          = srcq[i][0][16];
          ingress_port_tdata[i*16 +: 16] = srcq[i][0][15:0];
          bubble_now[i]                  = 1'b0;
        end else begin
          ingress_port_tvalid[i]         = 1'b0;
          ingress_port_tlast[i]          = 1'b0;
          ingress_port_tdata[i*16 +: 16] = 16'h0000;
          bubble_now[i]                  = (srcq[i].size() > 0);
        end
      end
    end
  end

  // ---------------- reference model and per-cycle compare
  typedef struct {
    int          port;
    logic [15:0] d;
    logic        last;
    int          cyc;
  } beat_t;
  beat_t log_q[$];

  int m_owner = -1;   // port currently owning the egress, -1 when no frame in progress
  int m_ptr   = 0;    // port with highest priority for the next frame

  initial begin
    logic [3:0]  e_grant, e_rdy;
    logic [15:0] e_dat;
    logic        e_vld, e_lst;
    beat_t       b;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        m_owner = -1;
        m_ptr   = 0;
        e_grant = 4'b0; e_rdy = 4'b0; e_dat = 16'h0; e_vld = 1'b0; e_lst = 1'b0;
      end else if (m_owner < 0) begin
        e_grant = 4'b0; e_rdy = 4'b0; e_dat = 16'h0; e_vld = 1'b0; e_lst = 1'b0;
      end else begin
        e_grant = 4'(1 << m_owner);
        e_rdy   = egress_port_tready ? e_grant : 4'b0;
        e_dat   = ingress_port_tdata[m_owner*16 +: 16];
        e_vld   = ingress_port_tvalid[m_owner];
        e_lst   = ingress_port_tlast[m_owner];
      end
      chk("grant",  64'(grant), 64'(e_grant));
      chk("ingress_tready", 64'(ingress_port_tready), 64'(e_rdy));
      chk("egress_tvalid", 64'(egress_port_tvalid), 64'(e_vld));
      chk("egress_tlast",  64'(egress_port_tlast),  64'(e_lst));
      chk("egress_tdata",  64'(egress_port_tdata),  64'(e_dat));
      if (egress_port_tvalid && egress_port_tready && !reset) begin
        b.port = -1;
        for (int k = 0; k < 4; k++) if (grant[k]) b.port = k;
        b.d    = egress_port_tdata;
        b.last = egress_port_tlast;
        b.cyc  = cyc;
        log_q.push_back(b);
      end
      if (!reset) begin
        if (m_owner < 0) begin
          for (int k = 3; k >= 0; k--)
            if (ingress_port_tvalid[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        end else if (ingress_port_tvalid[m_owner] && ingress_port_tlast[m_owner] && egress_port_tready) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
        end
      end
    end
  end

  // ---------------- helpers for the directed scenarios
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    clear_sources();
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_drained(input string nm);
    int n = 0;
    @(negedge clk);
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() != 0 || grant != 4'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s: traffic did not drain, got grant %b expected 0000", nm, grant);
    end
  endtask

  task automatic wait_grant(input string nm, input logic [3:0] g);
    int n = 0;
    while (grant !== g && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL %s: grant got %b expected %b", nm, grant, g);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_grant", 64'(grant), 64'h0);
    chk("reset_egress_tvalid", 64'(egress_port_tvalid), 64'h0);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_grant", 64'(grant), 64'h0);
    chk("idle_tready", 64'(ingress_port_tready), 64'h0);

    // Port 2 alone, three beats.
    log_q.delete();
    push_beat(2, 16'h1111, 1'b0);
    push_beat(2, 16'h2222, 1'b0);
    push_beat(2, 16'h3333, 1'b1);
    @(negedge clk);
    chk("p2_grant_request_cycle", 64'(grant), 64'h0);
    @(negedge clk);
    chk("p2_grant_next_cycle", 64'(grant), 64'h4);
    wait_drained("p2_drain");
    chk("p2_beats", 64'(log_q.size()), 64'd3);
    if (log_q.size() == 3) begin
      chk("p2_beat0", {log_q[0].last, log_q[0].d}, {1'b0, 16'h1111});
      chk("p2_beat1", {log_q[1].last, log_q[1].d}, {1'b0, 16'h2222});
      chk("p2_beat2", {log_q[2].last, log_q[2].d}, {1'b1, 16'h3333});
      chk("p2_port",  64'(log_q[2].port), 64'd2);
      chk("p2_back_to_back", 64'(log_q[2].cyc - log_q[0].cyc), 64'd2);
    end
    // Pointer now sits at port 3: port 3 must beat port 0.
    log_q.delete();
    push_beat(0, 16'h0A0A, 1'b1);
    push_beat(3, 16'h3A3A, 1'b1);
    wait_drained("ptr3_drain");
    if (log_q.size() == 2) begin
      chk("ptr3_first_port",  64'(log_q[0].port), 64'd3);
      chk("ptr3_second_port", 64'(log_q[1].port), 64'd0);
    end else chk("ptr3_beats", 64'(log_q.size()), 64'd2);

    // All four ports with 2-beat frames from reset.
    do_reset();
    log_q.delete();
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      push_beat(p, 16'hA000 + 16'(p * 256), 1'b0);
      push_beat(p, 16'hA001 + 16'(p * 256), 1'b1);
    end
    wait_drained("rr_drain");
    chk("rr_beats", 64'(log_q.size()), 64'd8);
    if (log_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("rr_port", 64'(log_q[k].port), 64'(k / 2));
        chk("rr_data", {log_q[k].last, log_q[k].d}, {(k % 2 == 1), 16'hA000 + 16'((k / 2) * 256 + k % 2)});
        if (k > 0) chk("rr_spacing", 64'(log_q[k].cyc - log_q[k-1].cyc), (k % 2 == 1) ? 64'd1 : 64'd2);
      end
    end

    // Port 1 stalled by the egress mid-frame while port 0 requests; includes a source bubble.
    log_q.delete();
    push_beat(1, 16'h1B01, 1'b0);
    push_bubble(1);
    push_beat(1, 16'h1B02, 1'b0);
    push_beat(1, 16'h1B03, 1'b0);
    push_beat(1, 16'h1B04, 1'b1);
    wait_grant("stall_grant", 4'b0010);
    push_beat(0, 16'h0C01, 1'b0);
    push_beat(0, 16'h0C02, 1'b1);
    n = 0;
    while (!(egress_port_tvalid && egress_port_tdata == 16'h1B02) && n < 50) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("stall_reach_b2", 64'(n < 50), 64'd1);
    @(posedge clk);
    #2;
    egress_port_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_data", 64'(egress_port_tdata), 64'h1B03);
      chk("stall_tready", 64'(ingress_port_tready), 64'h0);
      chk("stall_grant_held", 64'(grant), 64'h2);
    end
    @(posedge clk);
    #2;
    egress_port_tready = 1'b1;
    wait_drained("stall_drain");
    chk("stall_beats", 64'(log_q.size()), 64'd6);
    if (log_q.size() == 6) begin
      chk("stall_b0", 64'(log_q[0].d), 64'h1B01);
      chk("stall_b2", 64'(log_q[2].d), 64'h1B03);
      chk("stall_b3", {log_q[3].last, log_q[3].d}, {1'b1, 16'h1B04});
      chk("stall_p0_after", {4'(log_q[4].port), log_q[4].d}, {4'd0, 16'h0C01});
    end

    // Port 3 single-beat frame.
    log_q.delete();
    push_beat(3, 16'h3C3C, 1'b1);
    wait_grant("single_grant", 4'b1000);
    chk("single_tlast", {egress_port_tvalid, egress_port_tlast, egress_port_tdata}, {2'b11, 16'h3C3C});
    @(negedge clk);
    chk("single_idle_after", {grant, egress_port_tvalid}, 5'b0);

    // Reset in the middle of a 4-beat port 0 frame.
    do_reset();
    for (int b = 0; b < 4; b++) push_beat(0, 16'hD000 + 16'(b), (b == 3));
    n = 0;
    while (!(egress_port_tvalid && egress_port_tdata == 16'hD001) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_b2", 64'(n < 50), 64'd1);
    #2;
    reset = 1'b1;
    clear_sources();
    #1;
    chk("rst_async_egress", {egress_port_tvalid, egress_port_tlast, egress_port_tdata}, 64'h0);
    chk("rst_async_grant_rdy", {grant, ingress_port_tready}, 64'h0);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    log_q.delete();
    @(negedge clk);
    push_beat(1, 16'h1E01, 1'b1);
    push_beat(0, 16'h0E01, 1'b1);
    wait_drained("rst_restart_drain");
    if (log_q.size() == 2) begin
      chk("rst_restart_first", 64'(log_q[0].port), 64'd0);
      chk("rst_no_stale_tail", 64'(log_q[0].d), 64'h0E01);
    end else chk("rst_restart_beats", 64'(log_q.size()), 64'd2);

`ifdef ARB_STATS_EN
    do_reset();
    for (int f = 0; f < 3; f++) begin
      push_beat(0, 16'hF000 + 16'(f), 1'b0);
      push_beat(0, 16'hF100 + 16'(f), 1'b1);
    end
    wait_drained("stats_drain");
    chipselect = 1'b1; read = 1'b1; address = 8'd0;
    @(negedge clk);
    chk("stats_addr0", 64'(readdata), 64'h03);
    address = 8'd1;
    @(negedge clk);
    chk("stats_addr1", 64'(readdata), 64'h00);
    address = 8'd0;
    @(negedge clk);
    chk("stats_addr0_again", 64'(readdata), 64'h03);
    chipselect = 1'b0; read = 1'b0;
    @(negedge clk);
    chk("stats_no_read", 64'(readdata), 64'h00);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
